// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: widths, opcodes, fetch states.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Instruction opcodes, held in word[7:5].
    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_t;

    // Fetch unit sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction words
// over a req/ack port, hands opcode/operand to the controller over
// valid/ready, then applies halt, jump or skip when execution finishes.
module fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    input  logic              exec_done,
    input  logic              stop,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              skip,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fetch_state_t      state;
    logic [DATA_W-1:0] ir;

    // The address bus is the program counter itself; pc only moves on the
    // ack edge, so the address stays stable for the whole read.
    assign mem_addr = pc;

    // Opcode and operand are fields of the instruction register, which only
    // loads on a fetch handshake, so they hold while waiting for instr_ready.
    assign opcode  = ir[DATA_W-1 -: 3];
    assign operand = ir[ADDR_W-1:0];

    // Sequencer: state, pc, instruction register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            ir          <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values of the others (e.g. pc+1 uses the old pc).
            case (state)
                ST_IDLE: begin
                    mem_req <= 1'b1;
                    state   <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (mem_ack) begin
                        ir          <= mem_rdata;
                        pc          <= pc + PC_ONE;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (exec_done) begin
                        if (stop) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            if (redirect) begin
                                pc <= redirect_addr;
                            end else if (skip && acc_zero) begin
                                pc <= pc + PC_ONE;
                            end
                            mem_req <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                end

                ST_HALT: begin
                    halted <= 1'b1;
                end

                default: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an instruction-level reference model
// predicts every output each cycle while directed and random programs run.
module tb_fetch_unit;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int NADDR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [2:0]    opcode;
    logic [AW-1:0] operand;
    logic          exec_done = 1'b0;
    logic          stop = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          skip = 1'b0;
    logic          acc_zero = 1'b0;
    logic [AW-1:0] pc;
    logic          halted;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .operand       (operand),
        .exec_done     (exec_done),
        .stop          (stop),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .skip          (skip),
        .acc_zero      (acc_zero),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [DW-1:0] mem_img [NADDR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_expired(input string name);
        n_checks++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks which handshake the unit is waiting for, the program counter
    // and the last fetched word, using plain integer arithmetic.
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_ISSUE = 2;
    localparam int M_EXEC  = 3;
    localparam int M_HALT  = 4;

    int m_step = M_IDLE;
    int m_pc   = 0;
    int m_word = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step = M_IDLE;
            m_pc   = 0;
            m_word = 0;
        end else begin
            case (m_step)
                M_IDLE:  m_step = M_FETCH;
                M_FETCH: if (mem_ack) begin
                    m_word = int'(mem_rdata);
                    m_pc   = (m_pc + 1) % NADDR;
                    m_step = M_ISSUE;
                end
                M_ISSUE: if (instr_ready) m_step = M_EXEC;
                M_EXEC:  if (exec_done) begin
                    if (stop) m_step = M_HALT;
                    else begin
                        if (redirect) m_pc = int'(redirect_addr);
                        else if (skip && acc_zero) m_pc = (m_pc + 1) % NADDR;
                        m_step = M_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        check("mem_req", 32'(mem_req), 32'(m_step == M_FETCH));
        if (m_step == M_FETCH) check("mem_addr", 32'(mem_addr), m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_step == M_ISSUE));
        check("opcode", 32'(opcode), m_word / 32);
        check("operand", 32'(operand), m_word % 32);
        check("pc", 32'(pc), m_pc);
        check("halted", 32'(halted), 32'(m_step == M_HALT));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int seen);
        int n = 0;
        while (!mem_req && n < 60) begin
            tick();
            n++;
        end
        if (!mem_req) wait_expired("wait_mem_req");
        seen = cyc;
    endtask

    task automatic fetch_ack(input int dly);
        for (int i = 0; i < dly; i++) begin
            mem_ack     = 1'b0;
            mem_rdata   = 8'($urandom);
            instr_ready = 1'($urandom);
            tick();
        end
        instr_ready = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = mem_img[mem_addr];
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
    endtask

    task automatic do_issue(input int dly);
        int n = 0;
        while (!instr_valid && n < 60) begin
            tick();
            n++;
        end
        if (!instr_valid) wait_expired("wait_instr_valid");
        for (int i = 0; i < dly; i++) begin
            instr_ready = 1'b0;
            mem_ack     = 1'($urandom);
            tick();
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic do_exec(input int dly, input bit st, input bit rd, input int ra,
                           input bit sk, input bit az);
        for (int i = 0; i < dly; i++) begin
            exec_done     = 1'b0;
            stop          = 1'($urandom);
            redirect      = 1'($urandom);
            redirect_addr = 5'($urandom);
            skip          = 1'($urandom);
            acc_zero      = 1'($urandom);
            mem_ack       = 1'($urandom);
            instr_ready   = 1'($urandom);
            tick();
        end
        exec_done     = 1'b1;
        stop          = st;
        redirect      = rd;
        redirect_addr = 5'(ra);
        skip          = sk;
        acc_zero      = az;
        mem_ack       = 1'($urandom);
        instr_ready   = 1'($urandom);
        tick();
        exec_done   = 1'b0;
        stop        = 1'b0;
        redirect    = 1'b0;
        skip        = 1'b0;
        acc_zero    = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
    endtask

    // One full instruction with the given delays and end-of-execute flags.
    task automatic run_instr(input int fd, input int rdly, input int edly, input bit st,
                             input bit rd, input int ra, input bit sk, input bit az);
        int seen;
        wait_req(seen);
        fetch_ack(fd);
        do_issue(rdly);
        do_exec(edly, st, rd, ra, sk, az);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, edges, seen;

        for (int i = 0; i < NADDR; i++) mem_img[i] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // First instruction: ADD 5 at address 0, zero-wait handshakes.
        mem_img[0] = 8'h45;
        edges = 0;
        while (!mem_req && edges < 10) begin
            tick();
            edges++;
        end
        check("first_req_edge", edges, 1);
        wait_req(t0);
        fetch_ack(0);
        check("first_opcode", 32'(opcode), 32'h2);
        check("first_operand", 32'(operand), 32'h5);
        check("first_pc", 32'(pc), 32'h1);
        check("model_pc_pin", m_pc, 1);
        check("model_opcode_pin", m_word / 32, 2);
        do_issue(0);
        do_exec(0, 0, 0, 0, 0, 0);
        wait_req(t1);
        check("cycles_per_instr", t1 - t0, 3);
        check("second_fetch_addr", 32'(mem_addr), 32'h1);

        // Delayed ack and ready: one IR load, one pc increment.
        mem_img[1] = 8'h7B;
        fetch_ack(4);
        check("delayed_pc", 32'(pc), 32'h2);
        do_issue(3);
        check("delayed_pc_after_issue", 32'(pc), 32'h2);
        check("delayed_operand", 32'(operand), 32'h1B);
        do_exec(0, 0, 0, 0, 0, 0);

        // Plain instruction at 2, then JMP 10 at 3.
        mem_img[2] = 8'hA1;
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        mem_img[3] = 8'hEA;
        run_instr(0, 0, 0, 0, 1, 10, 0, 0);
        wait_req(seen);
        check("jump_addr", 32'(mem_addr), 32'd10);

        // Redirect beats skip.
        mem_img[10] = 8'hFF;
        run_instr(0, 0, 0, 0, 1, 10, 1, 1);
        wait_req(seen);
        check("redirect_over_skip", 32'(mem_addr), 32'd10);

        // Jump to 31, SKZ there with acc_zero=1 wraps to 1.
        run_instr(0, 0, 0, 0, 1, 31, 0, 0);
        wait_req(seen);
        check("jump_to_31", 32'(mem_addr), 32'd31);
        mem_img[31] = 8'h3F;
        run_instr(0, 0, 0, 0, 0, 0, 1, 1);
        wait_req(seen);
        check("skip_wrap_addr", 32'(mem_addr), 32'd1);

        // Back to 31, SKZ with acc_zero=0 continues at 0.
        mem_img[1] = 8'hFF;
        run_instr(0, 0, 0, 0, 1, 31, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 1, 0);
        wait_req(seen);
        check("noskip_wrap_addr", 32'(mem_addr), 32'd0);

        // Random program with random delays and end-of-execute flags.
        for (int i = 0; i < NADDR; i++) mem_img[i] = 8'($urandom);
        for (int k = 0; k < 40; k++) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                      ($urandom_range(0, 3) == 0), $urandom_range(0, NADDR - 1),
                      1'($urandom), 1'($urandom));
        end

        // Halt: stop wins over redirect and skip, then nothing moves.
        run_instr(0, 0, 1, 1, 1, 5, 1, 1);
        check("halted_set", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            mem_ack     = 1'($urandom);
            instr_ready = 1'($urandom);
            mem_rdata   = 8'($urandom);
            tick();
            check("halt_no_req", 32'(mem_req), 32'h0);
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b0;

        // Reset out of HALT, reach pc=7, then reset while waiting for ack.
        rst_n = 1'b0;
        #1;
        check("reset_clears_halted", 32'(halted), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        mem_img[0] = 8'hE7;
        run_instr(0, 0, 0, 0, 1, 7, 0, 0);
        wait_req(seen);
        check("pre_reset_addr", 32'(mem_addr), 32'd7);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_req", 32'(mem_req), 32'h0);
        check("async_reset_pc", 32'(pc), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("late_ack_ignored_pc", 32'(pc), 32'h0);
        mem_img[0] = 8'h45;
        wait_req(seen);
        check("restart_addr", 32'(mem_addr), 32'h0);
        fetch_ack(0);
        check("restart_opcode", 32'(opcode), 32'h2);
        check("restart_pc", 32'(pc), 32'h1);
        do_issue(0);
        do_exec(0, 0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule
